// File: rtl/flash_sample_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module   : flash_sample_sequencer_if
// Desc     : Control, flash word-read and sample-stream signals of the
//            flash sample sequencer. master = sequencer, slave = environment.
// Revision : 1.0
// ============================================================================
interface flash_sample_sequencer_if;
    logic        en;
    logic        restart;
    logic        dir;
    logic        rd_req;
    logic [22:0] rd_addr;
    logic [31:0] rd_data;
    logic        rd_valid;
    logic [15:0] smp_data;
    logic        smp_valid;
    logic        smp_ready;

    modport master (
        input  en,
        input  restart,
        input  dir,
        output rd_req,
        output rd_addr,
        input  rd_data,
        input  rd_valid,
        output smp_data,
        output smp_valid,
        input  smp_ready
    );

    modport slave (
        output en,
        output restart,
        output dir,
        input  rd_req,
        input  rd_addr,
        output rd_data,
        output rd_valid,
        input  smp_data,
        input  smp_valid,
        output smp_ready
    );
endinterface
`default_nettype wire

// File: rtl/flash_sample_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : flash_sample_sequencer
// Desc     : Fetches 32-bit words from a flash word reader and streams each
//            one as two signed 16-bit samples. Define REVERSE_PLAYBACK_EN to
//            enable reverse playback selected by dir.
// Revision : 1.0
// ============================================================================
module flash_sample_sequencer #(
    parameter logic [22:0] START_ADDR = 23'h000000,
    parameter logic [22:0] END_ADDR   = 23'h07FFFF
) (
    input  logic                     clk,
    input  logic                     rst_n,
    flash_sample_sequencer_if.master bus
);

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        REQ        = 3'd1,
        WAIT       = 3'd2,
        OUT_FIRST  = 3'd3,
        OUT_SECOND = 3'd4
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [22:0] r_addr;
    logic [22:0] w_addr_nxt;
    logic [31:0] r_word;
    logic [31:0] w_word_nxt;
    logic        r_restart_pend;
    logic        w_restart_pend_nxt;
    logic        r_rd_req;
    logic        r_smp_valid;
    logic [15:0] r_smp_data;
    logic [15:0] w_smp_data_nxt;

    logic        w_hs;
    logic        w_restart_any;
    logic        w_load_dir;
    logic        w_dir_now;
    logic        w_word_rev;
    logic [22:0] w_restart_addr;
    logic [22:0] w_step_addr;

    assign w_hs          = r_smp_valid & bus.smp_ready;
    assign w_restart_any = r_restart_pend | bus.restart;

    // Direction is taken live at each word boundary and latched for the
    // half-word ordering of the word that follows.
`ifdef REVERSE_PLAYBACK_EN
    logic r_dir;

    assign w_dir_now  = bus.dir;
    assign w_word_rev = r_dir;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_dir <= 1'b0;
        end else if (w_load_dir) begin
            r_dir <= w_dir_now;
        end
    end
`else
    logic w_unused_dir;

    assign w_dir_now    = 1'b0;
    assign w_word_rev   = 1'b0;
    assign w_unused_dir = bus.dir ^ w_load_dir;
`endif

    always_comb begin
        w_restart_addr = w_dir_now ? END_ADDR : START_ADDR;
        if (w_dir_now) begin
            w_step_addr = (r_addr == START_ADDR) ? END_ADDR : (r_addr - 23'd1);
        end else begin
            w_step_addr = (r_addr == END_ADDR) ? START_ADDR : (r_addr + 23'd1);
        end
    end

    always_comb begin
        w_state_nxt        = r_state;
        w_addr_nxt         = r_addr;
        w_word_nxt         = r_word;
        w_restart_pend_nxt = r_restart_pend | bus.restart;
        w_load_dir         = 1'b0;

        case (r_state)
            IDLE: begin
                if (w_restart_any) begin
                    w_addr_nxt         = w_restart_addr;
                    w_restart_pend_nxt = 1'b0;
                end
                if (bus.en) begin
                    w_state_nxt = REQ;
                    w_load_dir  = 1'b1;
                end
            end
            REQ: begin
                w_state_nxt = WAIT;
            end
            WAIT: begin
                if (bus.rd_valid) begin
                    w_word_nxt  = bus.rd_data;
                    w_state_nxt = OUT_FIRST;
                end
            end
            OUT_FIRST: begin
                if (w_hs) begin
                    w_state_nxt = OUT_SECOND;
                end
            end
            OUT_SECOND: begin
                if (w_hs) begin
                    // A restart (pending or arriving now) beats a normal step or wrap.
                    w_addr_nxt         = w_restart_any ? w_restart_addr : w_step_addr;
                    w_restart_pend_nxt = 1'b0;
                    if (bus.en) begin
                        w_state_nxt = REQ;
                        w_load_dir  = 1'b1;
                    end else begin
                        w_state_nxt = IDLE;
                    end
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    always_comb begin
        w_smp_data_nxt = r_smp_data;
        if ((r_state == WAIT) && (w_state_nxt == OUT_FIRST)) begin
            w_smp_data_nxt = w_word_rev ? w_word_nxt[31:16] : w_word_nxt[15:0];
        end else if ((r_state == OUT_FIRST) && (w_state_nxt == OUT_SECOND)) begin
            w_smp_data_nxt = w_word_rev ? r_word[15:0] : r_word[31:16];
        end
    end

    // Outputs are registered from the next state so smp_ready never reaches
    // smp_valid/smp_data combinationally.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state        <= IDLE;
            r_addr         <= START_ADDR;
            r_word         <= 32'h0;
            r_restart_pend <= 1'b0;
            r_rd_req       <= 1'b0;
            r_smp_valid    <= 1'b0;
            r_smp_data     <= 16'h0;
        end else begin
            r_state        <= w_state_nxt;
            r_addr         <= w_addr_nxt;
            r_word         <= w_word_nxt;
            r_restart_pend <= w_restart_pend_nxt;
            r_rd_req       <= (w_state_nxt == REQ) || (w_state_nxt == WAIT);
            r_smp_valid    <= (w_state_nxt == OUT_FIRST) || (w_state_nxt == OUT_SECOND);
            r_smp_data     <= w_smp_data_nxt;
        end
    end

    assign bus.rd_req    = r_rd_req;
    assign bus.rd_addr   = r_addr;
    assign bus.smp_valid = r_smp_valid;
    assign bus.smp_data  = r_smp_data;

endmodule
`default_nettype wire

// File: tb/tb_flash_sample_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_flash_sample_sequencer
// Desc     : Directed cycle-vector bench for flash_sample_sequencer
//            (START_ADDR=0, END_ADDR=3).
// Revision : 1.0
// ============================================================================
module tb_flash_sample_sequencer;

    localparam logic [22:0] C_START = 23'd0;
    localparam logic [22:0] C_END   = 23'd3;
    localparam int          C_LAT   = 3;

    typedef struct {
        logic        en;
        logic        restart;
        logic        rdy;
        logic        rv;
        logic [31:0] rdat;
        logic        xreq;
        logic [22:0] xaddr;
        logic        xsv;
        logic [15:0] xsd;
    } vec_t;

    logic clk;
    logic rst_n;
    logic dir_level;
    int   n_checks;
    int   n_errors;

    vec_t vq[$];
    vec_t dq[$];

    flash_sample_sequencer_if bus ();

    flash_sample_sequencer #(
        .START_ADDR (C_START),
        .END_ADDR   (C_END)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached, got no finish, expected finish");
        $fatal(1);
    end

    function automatic vec_t mk(input logic en, input logic rs, input logic rdy,
                                input logic rv, input logic [31:0] rdat,
                                input logic xreq, input logic [22:0] xaddr,
                                input logic xsv, input logic [15:0] xsd);
        vec_t v;
        v.en = en; v.restart = rs; v.rdy = rdy; v.rv = rv; v.rdat = rdat;
        v.xreq = xreq; v.xaddr = xaddr; v.xsv = xsv; v.xsd = xsd;
        return v;
    endfunction

    function automatic logic [31:0] mem_word(input logic [22:0] a);
        return {16'hA000 | a[15:0], 16'h5000 | a[15:0]};
    endfunction

    task automatic cmp(input string name, input logic xreq, input logic [22:0] xaddr,
                       input logic xsv, input logic [15:0] xsd);
        logic ok;
        n_checks++;
        ok = (bus.rd_req === xreq) && (bus.rd_addr === xaddr) &&
             (bus.smp_valid === xsv) && (!xsv || (bus.smp_data === xsd));
        if (!ok) begin
            n_errors++;
            $display("FAIL %s: got rd_req=%0b rd_addr=%0h smp_valid=%0b smp_data=%04h, expected rd_req=%0b rd_addr=%0h smp_valid=%0b smp_data=%04h",
                     name, bus.rd_req, bus.rd_addr, bus.smp_valid, bus.smp_data,
                     xreq, xaddr, xsv, xsd);
        end
    endtask

    task automatic chk_val(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h", name, got, exp);
        end
    endtask

    task automatic apply(input vec_t v, input string name);
        @(negedge clk);
        bus.en        = v.en;
        bus.restart   = v.restart;
        bus.dir       = dir_level;
        bus.smp_ready = v.rdy;
        bus.rd_valid  = v.rv;
        bus.rd_data   = v.rdat;
        @(posedge clk);
        #1;
        cmp(name, v.xreq, v.xaddr, v.xsv, v.xsd);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n         = 1'b0;
        bus.en        = 1'b0;
        bus.restart   = 1'b0;
        bus.dir       = 1'b0;
        bus.smp_ready = 1'b0;
        bus.rd_valid  = 1'b0;
        bus.rd_data   = 32'h0;
        dir_level     = 1'b0;
        @(posedge clk);
        #1;
        cmp("reset_outputs", 1'b0, C_START, 1'b0, 16'h0);
        chk_val("reset_smp_data", {16'h0, bus.smp_data}, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        logic        busy;
        int          cnt;
        logic [22:0] raddr;
        logic        got;
        int          starts[$];
        logic [22:0] addrs[$];
        logic [15:0] smps[$];
        int          max_period;
        logic [22:0] exp_addr[5];

        n_checks      = 0;
        n_errors      = 0;
        rst_n         = 1'b0;
        dir_level     = 1'b0;
        bus.en        = 1'b0;
        bus.restart   = 1'b0;
        bus.dir       = 1'b0;
        bus.smp_ready = 1'b0;
        bus.rd_valid  = 1'b0;
        bus.rd_data   = 32'h0;

        // en rst rdy rv rd_data      | req addr sv smp_data
        vq.push_back(mk(1,0,1,0,32'h0,          1,0,0,16'h0));     // IDLE->REQ
        vq.push_back(mk(1,0,1,0,32'h0,          1,0,0,16'h0));     // WAIT
        vq.push_back(mk(1,0,1,0,32'h0,          1,0,0,16'h0));
        vq.push_back(mk(1,0,1,1,32'hBEEF_1234,  0,0,1,16'h1234));
        vq.push_back(mk(1,0,1,0,32'h0,          0,0,1,16'hBEEF));
        vq.push_back(mk(1,0,1,0,32'h0,          1,1,0,16'h0));     // next addr 1
        vq.push_back(mk(1,0,1,0,32'h0,          1,1,0,16'h0));
        vq.push_back(mk(1,0,0,1,32'h5678_9ABC,  0,1,1,16'h9ABC));
        vq.push_back(mk(1,0,0,0,32'h0,          0,1,1,16'h9ABC));  // stalled
        vq.push_back(mk(1,0,0,1,32'hDEAD_DEAD,  0,1,1,16'h9ABC));  // stray rd_valid
        vq.push_back(mk(1,0,0,0,32'h0,          0,1,1,16'h9ABC));
        vq.push_back(mk(1,0,0,0,32'h0,          0,1,1,16'h9ABC));
        vq.push_back(mk(1,0,0,0,32'h0,          0,1,1,16'h9ABC));
        vq.push_back(mk(1,0,1,0,32'h0,          0,1,1,16'h5678));
        vq.push_back(mk(1,0,1,0,32'h0,          1,2,0,16'h0));
        vq.push_back(mk(1,0,1,0,32'h0,          1,2,0,16'h0));
        vq.push_back(mk(1,1,1,0,32'h0,          1,2,0,16'h0));     // restart in WAIT
        vq.push_back(mk(1,0,1,1,32'h1111_2222,  0,2,1,16'h2222));
        vq.push_back(mk(1,0,1,0,32'h0,          0,2,1,16'h1111));
        vq.push_back(mk(1,0,1,0,32'h0,          1,0,0,16'h0));     // reloaded
        vq.push_back(mk(1,0,1,0,32'h0,          1,0,0,16'h0));
        vq.push_back(mk(1,0,1,1,32'hCAFE_F00D,  0,0,1,16'hF00D));
        vq.push_back(mk(0,0,0,0,32'h0,          0,0,1,16'hF00D));  // en dropped
        vq.push_back(mk(0,0,1,0,32'h0,          0,0,1,16'hCAFE));
        vq.push_back(mk(0,0,1,0,32'h0,          0,1,0,16'h0));     // IDLE
        vq.push_back(mk(0,0,1,0,32'h0,          0,1,0,16'h0));
        vq.push_back(mk(0,1,1,0,32'h0,          0,0,0,16'h0));     // restart in IDLE
        vq.push_back(mk(1,0,1,0,32'h0,          1,0,0,16'h0));
        vq.push_back(mk(1,0,1,0,32'h0,          1,0,0,16'h0));
        vq.push_back(mk(1,0,1,1,32'h0002_0001,  0,0,1,16'h0001));
        vq.push_back(mk(1,0,1,0,32'h0,          0,0,1,16'h0002));
        vq.push_back(mk(1,0,1,0,32'h0,          1,1,0,16'h0));
        vq.push_back(mk(1,0,1,0,32'h0,          1,1,0,16'h0));
        vq.push_back(mk(1,0,1,1,32'h0004_0003,  0,1,1,16'h0003));
        vq.push_back(mk(1,0,1,0,32'h0,          0,1,1,16'h0004));
        vq.push_back(mk(1,1,1,0,32'h0,          1,0,0,16'h0));     // restart on handshake
        vq.push_back(mk(0,0,1,0,32'h0,          1,0,0,16'h0));     // en low in REQ
        vq.push_back(mk(0,0,1,1,32'h0006_0005,  0,0,1,16'h0005));
        vq.push_back(mk(0,0,1,0,32'h0,          0,0,1,16'h0006));
        vq.push_back(mk(0,0,1,0,32'h0,          0,1,0,16'h0));

`ifdef REVERSE_PLAYBACK_EN
        dq.push_back(mk(1,0,1,0,32'h0,          1,0,0,16'h0));
        dq.push_back(mk(1,0,1,0,32'h0,          1,0,0,16'h0));
        dq.push_back(mk(1,0,1,1,32'hAAAA_5555,  0,0,1,16'hAAAA));
        dq.push_back(mk(1,0,1,0,32'h0,          0,0,1,16'h5555));
        dq.push_back(mk(1,0,1,0,32'h0,          1,3,0,16'h0));     // 0 wraps to END
        dq.push_back(mk(1,0,1,0,32'h0,          1,3,0,16'h0));
        dq.push_back(mk(0,0,1,1,32'h1234_5678,  0,3,1,16'h1234));
        dq.push_back(mk(0,0,1,0,32'h0,          0,3,1,16'h5678));
        dq.push_back(mk(0,0,1,0,32'h0,          0,2,0,16'h0));
        dq.push_back(mk(0,1,1,0,32'h0,          0,3,0,16'h0));     // reverse restart
`else
        dq.push_back(mk(1,0,1,0,32'h0,          1,0,0,16'h0));
        dq.push_back(mk(1,0,1,0,32'h0,          1,0,0,16'h0));
        dq.push_back(mk(1,0,1,1,32'hAAAA_5555,  0,0,1,16'h5555));
        dq.push_back(mk(1,0,1,0,32'h0,          0,0,1,16'hAAAA));
        dq.push_back(mk(0,0,1,0,32'h0,          0,1,0,16'h0));     // dir ignored
        dq.push_back(mk(0,1,1,0,32'h0,          0,0,0,16'h0));
`endif

        do_reset();
        for (int i = 0; i < vq.size(); i++) begin
            apply(vq[i], $sformatf("vec%0d", i));
        end

        // Reset during an outstanding read, then a late rd_valid.
        do_reset();
        @(negedge clk);
        bus.en        = 1'b1;
        bus.smp_ready = 1'b1;
        got           = 1'b0;
        for (int c = 0; c < 10 && !got; c++) begin
            @(posedge clk);
            #1;
            if (bus.rd_req === 1'b1) got = 1'b1;
        end
        chk_val("rst_req_seen", {31'h0, got}, 32'h1);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        cmp("rst_mid_read", 1'b0, C_START, 1'b0, 16'h0);
        @(negedge clk);
        bus.en = 1'b0;
        rst_n  = 1'b1;
        @(negedge clk);
        bus.rd_valid = 1'b1;
        bus.rd_data  = 32'h1234_5678;
        @(posedge clk);
        #1;
        cmp("stale_rd_valid", 1'b0, C_START, 1'b0, 16'h0);
        @(negedge clk);
        bus.rd_valid = 1'b0;
        @(posedge clk);
        #1;
        cmp("stale_rd_valid_after", 1'b0, C_START, 1'b0, 16'h0);

        // Free-running forward playback against a fixed-latency reader.
        do_reset();
        busy       = 1'b0;
        cnt        = 0;
        raddr      = 23'h0;
        bus.en        = 1'b1;
        bus.smp_ready = 1'b1;
        for (int cyc = 0; cyc < 200 && addrs.size() < 5; cyc++) begin
            @(negedge clk);
            if (bus.smp_valid && bus.smp_ready) smps.push_back(bus.smp_data);
            if (bus.rd_valid) begin
                bus.rd_valid = 1'b0;
            end else if (busy) begin
                cnt--;
                if (cnt == 0) begin
                    bus.rd_valid = 1'b1;
                    bus.rd_data  = mem_word(raddr);
                    busy         = 1'b0;
                end
            end else if (bus.rd_req) begin
                busy  = 1'b1;
                cnt   = C_LAT;
                raddr = bus.rd_addr;
                addrs.push_back(raddr);
                starts.push_back(cyc);
            end
        end
        @(negedge clk);
        bus.en       = 1'b0;
        bus.rd_valid = 1'b0;
        chk_val("run_read_count", addrs.size(), 5);
        exp_addr = '{23'd0, 23'd1, 23'd2, 23'd3, 23'd0};
        for (int k = 0; k < 5; k++) begin
            if (k < addrs.size()) begin
                chk_val($sformatf("run_addr%0d", k), {9'h0, addrs[k]}, {9'h0, exp_addr[k]});
            end
        end
        chk_val("run_sample_count_min", {31'h0, (smps.size() >= 8) ? 1'b1 : 1'b0}, 32'h1);
        for (int k = 0; k < 4; k++) begin
            if (2 * k + 1 < smps.size()) begin
                chk_val($sformatf("run_smp_lo%0d", k), {16'h0, smps[2*k]},   {16'h0, 16'h5000 | k[15:0]});
                chk_val($sformatf("run_smp_hi%0d", k), {16'h0, smps[2*k+1]}, {16'h0, 16'hA000 | k[15:0]});
            end
        end
        max_period = 0;
        for (int k = 1; k < starts.size(); k++) begin
            if (starts[k] - starts[k-1] > max_period) max_period = starts[k] - starts[k-1];
        end
        chk_val("run_word_period_ok", {31'h0, (max_period <= C_LAT + 4) ? 1'b1 : 1'b0}, 32'h1);

        // dir=1 playback.
        do_reset();
        dir_level = 1'b1;
        for (int i = 0; i < dq.size(); i++) begin
            apply(dq[i], $sformatf("dir%0d", i));
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
